// File: rtl/sm_para_drv.sv
// ============================================================================
// sm_para_drv : upstream command driver for a two-input FSM interface with
//               response capture and error recovery / retry.
// Rev 1.0
// ============================================================================
`default_nettype none

module sm_para_drv #(
    parameter int STEPS       = 8,
    parameter int RETRY_MAX   = 3,
    parameter int RECOVER_CYC = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [2*STEPS-1:0] seq,
    input  logic               o1,
    input  logic               o2,
    input  logic               err,
    output logic               i1,
    output logic               i2,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [1:0]         retries,
    output logic [2*STEPS-1:0] rsp_log
);

    localparam int             SW        = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0]  LAST_STEP = SW'(STEPS - 1);
    localparam logic [3:0]     RCV_LAST  = 4'(RECOVER_CYC - 1);
    localparam logic [1:0]     RETRY_LIM = 2'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_RECOVER = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t             state_q;
    logic [2*STEPS-1:0] seq_q;
    logic [SW-1:0]      step_q;
    logic [3:0]         rcnt_q;
    logic [1:0]         cmd_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;
    logic [1:0]         retries_q;
    logic [2*STEPS-1:0] rsp_q;

    logic [1:0]         next_cmd_d;
    logic [SW-1:0]      log_idx_d;
    logic               resp_edge_d;

    // The response on this edge belongs to the step presented one cycle earlier;
    // in DRAIN the step index still points at the last step.
    always_comb begin
        next_cmd_d  = 2'b00;
        resp_edge_d = ((state_q == S_DRIVE) && (step_q != '0)) || (state_q == S_DRAIN);
        log_idx_d   = (state_q == S_DRAIN) ? step_q : (step_q - SW'(1));
        for (int k = 0; k < STEPS; k++) begin
            if ((step_q + SW'(1)) == SW'(k)) begin
                next_cmd_d = seq_q[2*k +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            seq_q     <= '0;
            step_q    <= '0;
            rcnt_q    <= '0;
            cmd_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            retries_q <= 2'd0;
            rsp_q     <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;

            if (resp_edge_d) begin
                for (int k = 0; k < STEPS; k++) begin
                    if (log_idx_d == SW'(k)) begin
                        rsp_q[2*k +: 2] <= {o1, o2};
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seq_q     <= seq;
                        retries_q <= 2'd0;
                        rsp_q     <= '0;
                        step_q    <= '0;
                        cmd_q     <= seq[1:0];
                        busy_q    <= 1'b1;
                        state_q   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (resp_edge_d && err) begin
                        cmd_q   <= 2'b00;
                        rcnt_q  <= '0;
                        state_q <= S_RECOVER;
                    end else if (step_q == LAST_STEP) begin
                        cmd_q   <= 2'b00;
                        state_q <= S_DRAIN;
                    end else begin
                        step_q  <= step_q + SW'(1);
                        cmd_q   <= next_cmd_d;
                    end
                end
                S_DRAIN: begin
                    if (err) begin
                        rcnt_q  <= '0;
                        state_q <= S_RECOVER;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_RECOVER: begin
                    if (rcnt_q == RCV_LAST) begin
                        if (retries_q < RETRY_LIM) begin
                            retries_q <= retries_q + 2'd1;
                            rsp_q     <= '0;
                            step_q    <= '0;
                            cmd_q     <= seq_q[1:0];
                            state_q   <= S_DRIVE;
                        end else begin
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end else begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i1      = cmd_q[1];
    assign i2      = cmd_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;
    assign retries = retries_q;
    assign rsp_log = rsp_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_para_drv.sv
// ============================================================================
// tb_sm_para_drv : randomized self-checking bench for sm_para_drv against a
//                  per-cycle schedule model built from the run rules.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sm_para_drv;

    localparam int STEPS       = 8;
    localparam int RETRY_MAX   = 3;
    localparam int RECOVER_CYC = 2;
    localparam int W           = 2 * STEPS;
    localparam int MAXN        = 128;

    logic         clk   = 1'b0;
    logic         nrst  = 1'b0;
    logic         start = 1'b0;
    logic         err   = 1'b0;
    logic [W-1:0] seq   = '0;
    logic         o1, o2;
    logic         i1, i2, busy, done, fail;
    logic [1:0]   retries;
    logic [W-1:0] rsp_log;

    sm_para_drv #(
        .STEPS      (STEPS),
        .RETRY_MAX  (RETRY_MAX),
        .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .seq    (seq),
        .o1     (o1),
        .o2     (o2),
        .err    (err),
        .i1     (i1),
        .i2     (i2),
        .busy   (busy),
        .done   (done),
        .fail   (fail),
        .retries(retries),
        .rsp_log(rsp_log)
    );

    always #5 clk = ~clk;

    // Responder: either echoes last cycle's command or plays a random vector.
    logic [1:0] echo_q    = 2'b00;
    logic [1:0] o_rand    = 2'b00;
    logic       echo_mode = 1'b1;
    always @(posedge clk) echo_q <= {i1, i2};
    assign o1 = echo_mode ? echo_q[1] : o_rand[1];
    assign o2 = echo_mode ? echo_q[0] : o_rand[0];

    int cyc_n    = 0;
    int done_cnt = 0;
    int fail_cnt = 0;
    int done_at  = -1;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_at = cyc_n;
        end
        if (fail) fail_cnt++;
    end

    logic [1:0]   exp_cmd [MAXN];
    bit           exp_busy[MAXN];
    bit           exp_done[MAXN];
    bit           exp_fail[MAXN];
    logic [1:0]   exp_ret [MAXN];
    logic [W-1:0] exp_log [MAXN];
    bit           err_vec [MAXN];
    logic [1:0]   o_vec   [MAXN];
    int           last_n;

    int tests  = 0;
    int failed = 0;

    task automatic put(input int n, input logic [1:0] c, input bit b, input bit d,
                       input bit f, input logic [1:0] r, input logic [W-1:0] l);
        exp_cmd[n]  = c;
        exp_busy[n] = b;
        exp_done[n] = d;
        exp_fail[n] = f;
        exp_ret[n]  = r;
        exp_log[n]  = l;
    endtask

    // Cycle n is the n-th cycle after the start edge. An attempt is STEPS
    // command cycles plus one drain cycle; the cycle at position p>=1 carries
    // the response to step p-1 and its err decides whether to retry.
    task automatic build_model(input logic [W-1:0] s, input bit echo);
        int         n;
        logic [1:0] ret;
        logic [W-1:0] lg;
        bit         fin, hit;
        logic [1:0] c;
        n = 1; ret = 2'd0; lg = '0; fin = 1'b0;
        while (!fin) begin
            hit = 1'b0;
            for (int p = 0; p <= STEPS && !hit; p++) begin
                c = (p < STEPS) ? s[2*p +: 2] : 2'b00;
                put(n, c, 1'b1, 1'b0, 1'b0, ret, lg);
                if (p >= 1) begin
                    lg[2*(p-1) +: 2] = echo ? exp_cmd[n-1] : o_vec[n];
                    hit = err_vec[n];
                end
                n++;
            end
            if (!hit) begin
                put(n, 2'b00, 1'b0, 1'b1, 1'b0, ret, lg);
                n++;
                fin = 1'b1;
            end else begin
                for (int r = 0; r < RECOVER_CYC; r++) begin
                    put(n, 2'b00, 1'b1, 1'b0, 1'b0, ret, lg);
                    n++;
                end
                if (int'(ret) < RETRY_MAX) begin
                    ret = ret + 2'd1;
                    lg  = '0;
                end else begin
                    put(n, 2'b00, 1'b0, 1'b0, 1'b1, ret, lg);
                    n++;
                    fin = 1'b1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            put(n, 2'b00, 1'b0, 1'b0, 1'b0, ret, lg);
            n++;
        end
        last_n = n - 1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic compare(input int n);
        tests++;
        if ({i1, i2} !== exp_cmd[n] || busy !== exp_busy[n] || done !== exp_done[n] ||
            fail !== exp_fail[n] || retries !== exp_ret[n] || rsp_log !== exp_log[n]) begin
            failed++;
            $display("FAIL cycle%0d: got cmd=%b busy=%b done=%b fail=%b ret=%0d log=%h, want cmd=%b busy=%b done=%b fail=%b ret=%0d log=%h",
                     n, {i1, i2}, busy, done, fail, retries, rsp_log,
                     exp_cmd[n], exp_busy[n], exp_done[n], exp_fail[n], exp_ret[n], exp_log[n]);
        end
    endtask

    task automatic clear_err();
        for (int n = 0; n < MAXN; n++) err_vec[n] = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] s, input bit echo, input int restart_at,
                       input int abort_at);
        build_model(s, echo);
        @(negedge clk);
        echo_mode = echo;
        start = 1'b1;
        seq   = s;
        for (int n = 1; n <= last_n; n++) begin
            @(posedge clk);
            #1;
            cyc_n  = n;
            start  = (n == restart_at);
            if (n == 1 || n == restart_at) seq = W'($urandom);
            err    = err_vec[n];
            o_rand = o_vec[n];
            if (n == abort_at) begin
                #2 nrst = 1'b0;
                err = 1'b0;
                #1 check("async_reset_outputs", {i1, i2, busy, done, fail, retries, rsp_log}, 64'd0);
                return;
            end
            @(negedge clk);
            compare(n);
        end
        err   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pd, pf;
        for (int n = 0; n < MAXN; n++) o_vec[n] = 2'($urandom_range(0, 3));
        clear_err();

        repeat (3) @(posedge clk);
        #1 check("reset_state", {i1, i2, busy, done, fail, retries, rsp_log}, 64'd0);
        @(negedge clk) nrst = 1'b1;

        // Clean run with echoing responder.
        pd = done_cnt;
        run(16'h1B6C, 1'b1, 0, 0);
        check("t1_model_step1_cmd", exp_cmd[2], 2'b11);
        check("t1_done_cycle", done_at, 10);
        check("t1_done_count", done_cnt - pd, 1);
        check("t1_rsp_log", rsp_log, 16'h1B6C);
        check("t1_retries", retries, 0);

        // Single err on the step-3 response.
        clear_err();
        err_vec[5] = 1'b1;
        run(16'h1B6C, 1'b1, 0, 0);
        check("t2_done_cycle", done_at, 17);
        check("t2_retries", retries, 1);
        check("t2_rsp_log", rsp_log, 16'h1B6C);

        // err held high: every first response errors, retries exhausted.
        for (int n = 0; n < MAXN; n++) err_vec[n] = 1'b1;
        pd = done_cnt; pf = fail_cnt;
        run(16'h2D71, 1'b1, 0, 0);
        check("t3_fail_count", fail_cnt - pf, 1);
        check("t3_done_count", done_cnt - pd, 0);
        check("t3_retries", retries, 3);

        // Restart attempt while busy with a different seq.
        clear_err();
        run(16'hC3A5, 1'b1, 3, 0);
        check("t4_done_cycle", done_at, 10);
        check("t4_rsp_log", rsp_log, 16'hC3A5);

        // err coincident with the drain sample.
        clear_err();
        err_vec[STEPS+1] = 1'b1;
        run(16'h96E4, 1'b1, 0, 0);
        check("t5_done_cycle", done_at, 21);
        check("t5_retries", retries, 1);

        // Async reset while step 4 is presented.
        clear_err();
        pd = done_cnt; pf = fail_cnt;
        run(16'hA5C3, 1'b1, 0, 5);
        repeat (3) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("t6_no_pulse", {32'(done_cnt - pd), 32'(fail_cnt - pf)}, 64'd0);
        check("t6_idle_after_reset", {i1, i2, busy, retries, rsp_log}, 64'd0);
        run(16'h5A3C, 1'b1, 0, 0);
        check("t6_rerun_log", rsp_log, 16'h5A3C);

        // Randomized runs: random seq, sparse err, echo or random responses.
        for (int t = 0; t < 24; t++) begin
            for (int n = 0; n < MAXN; n++) begin
                err_vec[n] = ($urandom_range(0, 99) < 5);
                o_vec[n]   = 2'($urandom_range(0, 3));
            end
            run(W'($urandom), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
